// File: rtl/timer_pkg.sv
// +------------------------------------------------------------------+
// | timer_pkg: shared encodings and constants for the delay timer     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package timer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_CNT  = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_ACK       = 3'd4,
      ST_GAP       = 3'd5
   } state_e;

   localparam logic [3:0] TMR_START    = 4'hD;
   localparam int         TMR_DLY_W    = 4;
   localparam int         TMR_UNIT_CYC = 1000;

   // Bit idx of the 8-bit frame {start, dly}, MSB first.
   function automatic logic send_bit(input logic [2:0] idx,
                                     input logic [3:0] start,
                                     input logic [3:0] dly);
      logic [7:0] frame;
      frame = {start, dly};
      return frame[3'd7 - idx];
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick, first req at/after ptr|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   always_comb begin
      int  c;
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            idx    = c[IW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/timer_req_scheduler.sv
// +------------------------------------------------------------------+
// | timer_req_scheduler: shares one serial-programmed delay timer     |
// | among N_REQ requesters with round-robin arbitration.              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module timer_req_scheduler
   import timer_pkg::*;
#(
   parameter int         N_REQ   = 4,
   parameter logic [3:0] START   = TMR_START,
   parameter int         TMO_CYC = 16,
   parameter int         GAP_CYC = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [4*N_REQ-1:0]     delay,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       fin,
   output logic                   err,
   output logic                   busy,
   output logic                   tmr_data,
   output logic                   tmr_ack,
   input  logic                   tmr_counting,
   input  logic                   tmr_done
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TMO_CYC + 1);
   localparam int GW = $clog2(GAP_CYC + 1);

   state_e                 state_q,    state_d;
   logic [IW-1:0]          rr_ptr_q,   rr_ptr_d;
   logic [TMR_DLY_W-1:0]   dly_q,      dly_d;
   logic [2:0]             bit_idx_q,  bit_idx_d;
   logic [TW-1:0]          tmo_cnt_q,  tmo_cnt_d;
   logic [GW-1:0]          gap_cnt_q,  gap_cnt_d;
   logic [N_REQ-1:0]       grant_q,    grant_d;
   logic [N_REQ-1:0]       fin_q,      fin_d;
   logic                   err_q,      err_d;
   logic                   tmr_data_q, tmr_data_d;
   logic                   tmr_ack_q,  tmr_ack_d;

   logic [N_REQ-1:0]       arb_gnt;
   logic [IW-1:0]          arb_idx;
   logic                   gap_ok;

   rr_arbiter #(
      .N  (N_REQ),
      .IW (IW)
   ) u_arb (
      .req (req),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign gap_ok = (gap_cnt_q == GW'(GAP_CYC));

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      dly_d      = dly_q;
      bit_idx_d  = bit_idx_q;
      tmo_cnt_d  = tmo_cnt_q;
      gap_cnt_d  = gap_ok ? gap_cnt_q : gap_cnt_q + GW'(1);
      grant_d    = grant_q;
      fin_d      = '0;
      err_d      = 1'b0;
      tmr_data_d = 1'b0;
      tmr_ack_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // The first frame bit is launched together with the grant.
            if ((|req) && gap_ok) begin
               grant_d    = arb_gnt;
               dly_d      = delay[arb_idx*TMR_DLY_W +: TMR_DLY_W];
               rr_ptr_d   = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
               bit_idx_d  = 3'd0;
               tmr_data_d = START[3];
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (bit_idx_q == 3'd7) begin
               tmo_cnt_d = '0;
               state_d   = ST_WAIT_CNT;
            end else begin
               bit_idx_d  = bit_idx_q + 3'd1;
               tmr_data_d = send_bit(bit_idx_q + 3'd1, START, dly_q);
            end
         end
         ST_WAIT_CNT: begin
            if (tmr_counting) begin
               state_d = ST_WAIT_DONE;
            end else if (tmo_cnt_q == TW'(TMO_CYC - 1)) begin
               err_d     = 1'b1;
               fin_d     = grant_q;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (tmr_done) begin
               tmr_ack_d = 1'b1;
               state_d   = ST_ACK;
            end
         end
         ST_ACK: begin
            if (tmr_done) begin
               tmr_ack_d = 1'b1;
            end else begin
               fin_d     = grant_q;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            // First GAP cycle is the fin cycle; grant is released after it.
            grant_d = '0;
            if (gap_cnt_q == GW'(GAP_CYC - 1)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         dly_q      <= '0;
         bit_idx_q  <= '0;
         tmo_cnt_q  <= '0;
         gap_cnt_q  <= GW'(GAP_CYC);
         grant_q    <= '0;
         fin_q      <= '0;
         err_q      <= 1'b0;
         tmr_data_q <= 1'b0;
         tmr_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         dly_q      <= dly_d;
         bit_idx_q  <= bit_idx_d;
         tmo_cnt_q  <= tmo_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         grant_q    <= grant_d;
         fin_q      <= fin_d;
         err_q      <= err_d;
         tmr_data_q <= tmr_data_d;
         tmr_ack_q  <= tmr_ack_d;
      end
   end

   assign grant    = grant_q;
   assign fin      = fin_q;
   assign err      = err_q;
   assign busy     = (state_q != ST_IDLE);
   assign tmr_data = tmr_data_q;
   assign tmr_ack  = tmr_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_req_scheduler.sv
// +------------------------------------------------------------------+
// | tb_timer_req_scheduler: directed bench with behavioural timer     |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_timer_req_scheduler;
   import timer_pkg::*;

   localparam int N_REQ   = 4;
   localparam int TMO_CYC = 16;
   localparam int GAP_CYC = 4;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic [N_REQ-1:0]     req = '0;
   logic [4*N_REQ-1:0]   delay = '0;
   logic [N_REQ-1:0]     grant;
   logic [N_REQ-1:0]     fin;
   logic                 err;
   logic                 busy;
   logic                 tmr_data;
   logic                 tmr_ack;
   logic                 tmr_counting = 1'b0;
   logic                 tmr_done = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   timer_req_scheduler #(
      .N_REQ   (N_REQ),
      .START   (4'hD),
      .TMO_CYC (TMO_CYC),
      .GAP_CYC (GAP_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .delay        (delay),
      .grant        (grant),
      .fin          (fin),
      .err          (err),
      .busy         (busy),
      .tmr_data     (tmr_data),
      .tmr_ack      (tmr_ack),
      .tmr_counting (tmr_counting),
      .tmr_done     (tmr_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural timer: decodes 1101+dly, counts (dly+1)*unit, then raises done.
   localparam int M_IDLE = 0, M_DLY = 1, M_RUN = 2, M_DONE = 3;
   int         m_state = M_IDLE;
   int         m_cnt = 0;
   logic [3:0] m_sr = '0;
   logic [3:0] m_dly = '0;
   bit         m_never_count = 1'b0;
   int         m_done_hold = 0;

   always @(negedge clk) begin
      if (reset) begin
         m_state      = M_IDLE;
         m_sr         = '0;
         tmr_counting = 1'b0;
         tmr_done     = 1'b0;
      end else begin
         case (m_state)
            M_IDLE: begin
               m_sr = {m_sr[2:0], tmr_data};
               if (m_sr == 4'hD) begin
                  m_state = M_DLY;
                  m_cnt   = 0;
               end
            end
            M_DLY: begin
               m_dly = {m_dly[2:0], tmr_data};
               m_cnt++;
               if (m_cnt == 4) begin
                  m_sr  = '0;
                  m_cnt = 0;
                  if (m_never_count) begin
                     m_state = M_IDLE;
                  end else begin
                     tmr_counting = 1'b1;
                     m_state      = M_RUN;
                  end
               end
            end
            M_RUN: begin
               m_cnt++;
               if (m_cnt == (int'(m_dly) + 1) * TMR_UNIT_CYC) begin
                  tmr_counting = 1'b0;
                  tmr_done     = 1'b1;
                  m_cnt        = 0;
                  m_state      = M_DONE;
               end
            end
            default: begin
               m_cnt++;
               if ((m_done_hold != 0) ? (m_cnt == m_done_hold) : (tmr_ack == 1'b1)) begin
                  tmr_done = 1'b0;
                  m_state  = M_IDLE;
               end
            end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Bench time point: just after the falling edge; inputs change and outputs are sampled here.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = '0;
      repeat (3) step();
      chk("reset_outputs", 32'({grant, fin, err, busy, tmr_data, tmr_ack}), 32'd0);
      reset = 1'b0;
   endtask

   task automatic wait_grant(input string tag, output int gcyc);
      int n;
      n = 0;
      step();
      while (grant == '0 && n < 20000) begin
         step();
         n++;
      end
      chk({tag, "_grant_seen"}, 32'(grant != '0), 32'd1);
      gcyc = cyc;
   endtask

   task automatic wait_fin(input string tag, output int fcyc);
      int n;
      n = 0;
      while (fin == '0 && n < 20000) begin
         step();
         n++;
      end
      chk({tag, "_fin_seen"}, 32'(fin != '0), 32'd1);
      fcyc = cyc;
   endtask

   task automatic get_seq(output logic [7:0] s);
      s = '0;
      for (int k = 0; k < 8; k++) begin
         s = {s[6:0], tmr_data};
         if (k < 7) step();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         t0, g, f, e, prev_f, n;
      logic [7:0] s;
      logic [N_REQ-1:0] exp_g;

      // 1: single job, delay A
      do_reset();
      delay = 16'h000A;
      req   = 4'b0001;
      t0    = cyc;
      wait_grant("t1", g);
      chk("t1_latency", 32'(g - t0), 32'd1);
      chk("t1_grant", 32'(grant), 32'h1);
      chk("t1_busy", 32'(busy), 32'd1);
      get_seq(s);
      chk("t1_frame", 32'(s), 32'hDA);
      wait_fin("t1", f);
      chk("t1_fin", 32'(fin), 32'h1);
      chk("t1_err", 32'(err), 32'd0);
      chk("t1_grant_at_fin", 32'(grant), 32'h1);
      chk("t1_duration", 32'(f - g), 32'd11009);
      req = '0;
      step();
      chk("t1_after_fin", 32'({grant, fin}), 32'd0);

      // 2: all requesting, strict rotation
      do_reset();
      delay  = {4'd3, 4'd2, 4'd1, 4'd0};
      req    = 4'b1111;
      prev_f = 0;
      for (int j = 0; j < 5; j++) begin
         exp_g = 4'b0001 << (j % 4);
         wait_grant("t2", g);
         chk($sformatf("t2_grant%0d", j), 32'(grant), 32'(exp_g));
         if (j > 0) chk($sformatf("t2_gap%0d", j), 32'(g - prev_f), 32'(GAP_CYC + 1));
         wait_fin("t2", f);
         chk($sformatf("t2_fin%0d", j), 32'(fin), 32'(exp_g));
         prev_f = f;
      end
      req = '0;

      // 3: timer never starts counting
      do_reset();
      m_never_count = 1'b1;
      delay = 16'h0500;
      req   = 4'b0100;
      wait_grant("t3", g);
      n = 0;
      while (!err && n < 100) begin
         step();
         n++;
      end
      e = cyc;
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_err_time", 32'(e - g), 32'(7 + TMO_CYC + 1));
      chk("t3_fin", 32'(fin), 32'h4);
      req = '0;
      m_never_count = 1'b0;
      repeat (3) step();
      chk("t3_busy_gap", 32'(busy), 32'd1);
      step();
      chk("t3_busy_idle", 32'(busy), 32'd0);

      // 4: owner drops req during WAIT_DONE
      do_reset();
      delay = 16'h0000;
      req   = 4'b0100;
      wait_grant("t4", g);
      repeat (20) step();
      req = '0;
      wait_fin("t4", f);
      chk("t4_fin", 32'(fin), 32'h4);
      chk("t4_err", 32'(err), 32'd0);
      n = 0;
      repeat (20) begin
         step();
         if (grant != '0) n++;
      end
      chk("t4_no_regrant", 32'(n), 32'd0);
      chk("t4_busy", 32'(busy), 32'd0);

      // 5: reset in SEND bit 5
      do_reset();
      delay = 16'h00F0;
      req   = 4'b0010;
      wait_grant("t5", g);
      repeat (5) step();
      reset = 1'b1;
      step();
      chk("t5_reset_outputs", 32'({grant, fin, err, busy, tmr_data, tmr_ack}), 32'd0);
      reset = 1'b0;
      delay = 16'h0030;
      req   = 4'b0110;
      wait_grant("t5", g);
      chk("t5_rr_ptr_cleared", 32'(grant), 32'h2);
      get_seq(s);
      chk("t5_frame", 32'(s), 32'hD3);
      req = '0;
      wait_fin("t5", f);
      chk("t5_fin", 32'(fin), 32'h2);

      // 6: done held for 3 cycles
      do_reset();
      m_done_hold = 3;
      delay = 16'h0000;
      req   = 4'b0001;
      wait_grant("t6", g);
      n = 0;
      while (!tmr_ack && n < 3000) begin
         step();
         n++;
      end
      req = '0;
      n = 0;
      while (tmr_ack && n < 10) begin
         chk("t6_fin_during_ack", 32'(fin), 32'd0);
         step();
         n++;
      end
      chk("t6_ack_len", 32'(n), 32'd3);
      chk("t6_fin", 32'(fin), 32'h1);
      m_done_hold = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
